// File: rtl/legv8_pkg.sv
// Shared LEGv8 execute-stage definitions: ALU function codes, ALUOp encodings and
// the R-type/I-type opcodes recognised by the ALU control decoder.
package legv8_pkg;

    typedef enum logic [3:0] {
        ALU_AND   = 4'b0000,
        ALU_ORR   = 4'b0001,
        ALU_ADD   = 4'b0010,
        ALU_EOR   = 4'b0011,
        ALU_SUB   = 4'b0110,
        ALU_PASSB = 4'b0111,
        ALU_NOR   = 4'b1100,
        ALU_BAD   = 4'b1111
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        ALUOP_LDST  = 2'b00,
        ALUOP_CBZ   = 2'b01,
        ALUOP_RTYPE = 2'b10,
        ALUOP_ITYPE = 2'b11
    } alu_op_e;

    localparam logic [10:0] OPC_ADD = 11'b10001011000;
    localparam logic [10:0] OPC_SUB = 11'b11001011000;
    localparam logic [10:0] OPC_AND = 11'b10001010000;
    localparam logic [10:0] OPC_ORR = 11'b10101010000;
    localparam logic [10:0] OPC_EOR = 11'b11001010000;

    localparam logic [9:0] OPI_ADDI = 10'b1001000100;
    localparam logic [9:0] OPI_SUBI = 10'b1101000100;
    localparam logic [9:0] OPI_ANDI = 10'b1001001000;
    localparam logic [9:0] OPI_ORRI = 10'b1011001000;

endpackage

// File: rtl/legv8_execute_unit_if.sv
// Execute-stage bus: operands and control in from decode, registered result and flags out.
interface legv8_execute_unit_if #(
    parameter int unsigned WIDTH = 64
);
    logic [1:0]       alu_op;
    logic [10:0]      opcode;
    logic             alu_src;
    logic [WIDTH-1:0] read1;
    logic [WIDTH-1:0] read2;
    logic [WIDTH-1:0] sign_ext;
    logic [3:0]       alu_ctrl;
    logic [WIDTH-1:0] alu_out;
    logic             zero;
    logic             negative;
    logic             carry;
    logic             overflow;
    logic             illegal;

    modport master (
        output alu_op, opcode, alu_src, read1, read2, sign_ext,
        input  alu_ctrl, alu_out, zero, negative, carry, overflow, illegal
    );

    modport slave (
        input  alu_op, opcode, alu_src, read1, read2, sign_ext,
        output alu_ctrl, alu_out, zero, negative, carry, overflow, illegal
    );
endinterface

// File: rtl/legv8_alu_decode.sv
// ALU control decoder: maps ALUOp and instruction[31:21] to a 4-bit ALU function code.
module legv8_alu_decode
    import legv8_pkg::*;
(
    input  logic [1:0]  alu_op,
    input  logic [10:0] opcode,
    output logic [3:0]  alu_ctrl,
    output logic        illegal
);

    always_comb begin
        alu_ctrl = ALU_BAD;
        illegal  = 1'b0;
        unique case (alu_op)
            ALUOP_LDST: alu_ctrl = ALU_ADD;
            ALUOP_CBZ:  alu_ctrl = ALU_PASSB;
            ALUOP_RTYPE: begin
                case (opcode)
                    OPC_ADD: alu_ctrl = ALU_ADD;
                    OPC_SUB: alu_ctrl = ALU_SUB;
                    OPC_AND: alu_ctrl = ALU_AND;
                    OPC_ORR: alu_ctrl = ALU_ORR;
                    OPC_EOR: alu_ctrl = ALU_EOR;
                    default: illegal  = 1'b1;
                endcase
            end
            ALUOP_ITYPE: begin
                // I-type opcodes are 10 bits; instruction[21] belongs to the immediate.
                case (opcode[10:1])
                    OPI_ADDI: alu_ctrl = ALU_ADD;
                    OPI_SUBI: alu_ctrl = ALU_SUB;
                    OPI_ANDI: alu_ctrl = ALU_AND;
                    OPI_ORRI: alu_ctrl = ALU_ORR;
                    default:  illegal  = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/legv8_execute_unit.sv
// LEGv8 execute stage: operand-B mux, ALU control decode and 64-bit ALU with
// result and NZCV-style flags registered once at the output.
module legv8_execute_unit
    import legv8_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input logic                  clock,
    input logic                  reset,
    legv8_execute_unit_if.slave  ex
);

    logic [3:0]       ctrl;
    logic             ctrl_illegal;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] b_addend;
    logic             is_sub;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] result;
    logic             carry_d;
    logic             overflow_d;

    logic [WIDTH-1:0] alu_out_q;
    logic             zero_q;
    logic             negative_q;
    logic             carry_q;
    logic             overflow_q;
    logic             illegal_q;

    legv8_alu_decode u_decode (
        .alu_op   (ex.alu_op),
        .opcode   (ex.opcode),
        .alu_ctrl (ctrl),
        .illegal  (ctrl_illegal)
    );

    assign op_a = ex.read1;
    assign op_b = ex.alu_src ? ex.sign_ext : ex.read2;

    // One adder serves both ADD and SUB; SUB feeds ~B with a carry-in of 1.
    always_comb begin
        is_sub   = (ctrl == ALU_SUB);
        b_addend = is_sub ? ~op_b : op_b;
        sum      = {1'b0, op_a} + {1'b0, b_addend} + {{WIDTH{1'b0}}, is_sub};
    end

    always_comb begin
        result     = '0;
        carry_d    = 1'b0;
        overflow_d = 1'b0;
        case (ctrl)
            ALU_AND:   result = op_a & op_b;
            ALU_ORR:   result = op_a | op_b;
            ALU_EOR:   result = op_a ^ op_b;
            ALU_PASSB: result = op_b;
            ALU_NOR:   result = ~(op_a | op_b);
            ALU_ADD, ALU_SUB: begin
                result     = sum[WIDTH-1:0];
                carry_d    = sum[WIDTH];
                overflow_d = (op_a[WIDTH-1] == b_addend[WIDTH-1]) &&
                             (sum[WIDTH-1] != op_a[WIDTH-1]);
            end
            default: result = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            alu_out_q  <= '0;
            zero_q     <= 1'b1;
            negative_q <= 1'b0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            alu_out_q  <= result;
            zero_q     <= (result == '0);
            negative_q <= result[WIDTH-1];
            carry_q    <= carry_d;
            overflow_q <= overflow_d;
            illegal_q  <= ctrl_illegal;
        end
    end

    assign ex.alu_ctrl = ctrl;
    assign ex.alu_out  = alu_out_q;
    assign ex.zero     = zero_q;
    assign ex.negative = negative_q;
    assign ex.carry    = carry_q;
    assign ex.overflow = overflow_q;
    assign ex.illegal  = illegal_q;

endmodule

// File: tb/tb_legv8_execute_unit.sv
// Scoreboard bench for legv8_execute_unit: expected results are queued at drive time
// and compared against the registered outputs one edge later.
module tb_legv8_execute_unit;

    typedef struct packed {
        logic [63:0] out;
        logic        z;
        logic        n;
        logic        c;
        logic        v;
        logic        ill;
    } exp_t;

    logic clock;
    logic reset;
    int   n_tests;
    int   n_fail;
    exp_t sb[$];

    legv8_execute_unit_if #(.WIDTH(64)) ex_if ();

    legv8_execute_unit #(.WIDTH(64)) dut (
        .clock (clock),
        .reset (reset),
        .ex    (ex_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] model_ctrl(input logic [1:0] aop, input logic [10:0] opc);
        if (aop == 2'b00) return 4'b0010;
        if (aop == 2'b01) return 4'b0111;
        if (aop == 2'b10) begin
            if (opc == 11'b10001011000) return 4'b0010;
            if (opc == 11'b11001011000) return 4'b0110;
            if (opc == 11'b10001010000) return 4'b0000;
            if (opc == 11'b10101010000) return 4'b0001;
            if (opc == 11'b11001010000) return 4'b0011;
            return 4'b1111;
        end
        if (opc[10:1] == 10'b1001000100) return 4'b0010;
        if (opc[10:1] == 10'b1101000100) return 4'b0110;
        if (opc[10:1] == 10'b1001001000) return 4'b0000;
        if (opc[10:1] == 10'b1011001000) return 4'b0001;
        return 4'b1111;
    endfunction

    function automatic exp_t model(input logic [3:0] ctrl, input logic [63:0] a,
                                   input logic [63:0] b);
        exp_t e;
        logic signed [65:0] wide;
        e = '0;
        e.ill = (ctrl == 4'b1111);
        case (ctrl)
            4'b0000: e.out = a & b;
            4'b0001: e.out = a | b;
            4'b0011: e.out = a ^ b;
            4'b0111: e.out = b;
            4'b0010: begin
                e.out = a + b;
                e.c   = (e.out < a);
                wide  = $signed({{2{a[63]}}, a}) + $signed({{2{b[63]}}, b});
                e.v   = (wide != $signed({{2{e.out[63]}}, e.out}));
            end
            4'b0110: begin
                e.out = a - b;
                e.c   = (a >= b);
                wide  = $signed({{2{a[63]}}, a}) - $signed({{2{b[63]}}, b});
                e.v   = (wide != $signed({{2{e.out[63]}}, e.out}));
            end
            default: e.out = '0;
        endcase
        e.z = (e.out == 64'd0);
        e.n = e.out[63];
        return e;
    endfunction

    task automatic step(input logic rst, input logic [1:0] aop, input logic [10:0] opc,
                        input logic src, input logic [63:0] r1, input logic [63:0] r2,
                        input logic [63:0] se);
        logic [3:0] ctrl;
        exp_t       e;
        exp_t       got;
        @(negedge clock);
        reset          = rst;
        ex_if.alu_op   = aop;
        ex_if.opcode   = opc;
        ex_if.alu_src  = src;
        ex_if.read1    = r1;
        ex_if.read2    = r2;
        ex_if.sign_ext = se;
        #1;
        ctrl = model_ctrl(aop, opc);
        check("alu_ctrl", {60'd0, ex_if.alu_ctrl}, {60'd0, ctrl});
        if (rst) e = '{out: 64'd0, z: 1'b1, n: 1'b0, c: 1'b0, v: 1'b0, ill: 1'b0};
        else     e = model(ctrl, r1, src ? se : r2);
        sb.push_back(e);
        @(posedge clock);
        #1;
        check("sb_level", 64'(sb.size()), 64'd1);
        if (sb.size() != 0) begin
            e   = sb.pop_front();
            got = '{out: ex_if.alu_out, z: ex_if.zero, n: ex_if.negative, c: ex_if.carry,
                    v: ex_if.overflow, ill: ex_if.illegal};
            check("alu_out",  got.out, e.out);
            check("zero",     64'(got.z), 64'(e.z));
            check("negative", 64'(got.n), 64'(e.n));
            check("carry",    64'(got.c), 64'(e.c));
            check("overflow", 64'(got.v), 64'(e.v));
            check("illegal",  64'(got.ill), 64'(e.ill));
        end
    endtask

    localparam logic [10:0] R_ADD = 11'b10001011000;
    localparam logic [10:0] R_SUB = 11'b11001011000;

    initial begin
        logic [10:0] opcs [0:9];
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        ex_if.alu_op   = 2'b10;
        ex_if.opcode   = R_ADD;
        ex_if.alu_src  = 1'b0;
        ex_if.read1    = 64'h1;
        ex_if.read2    = 64'h2;
        ex_if.sign_ext = 64'h3;
        opcs = '{11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000,
                 11'b11001010000, 11'b10010001000, 11'b11010001000, 11'b10010010000,
                 11'b10110010000, 11'b00000000000};

        // Reset held for two edges with non-zero inputs
        step(1'b1, 2'b10, R_ADD, 1'b0, 64'hAAAA, 64'h5555, 64'h1);
        step(1'b1, 2'b11, 11'b10010001001, 1'b1, 64'hFFFF_0000_0000_0001, 64'h9, 64'h7);

        // Directed cases
        step(1'b0, 2'b10, R_ADD, 1'b0, 64'd5, 64'd7, 64'd99);
        check("add_result", ex_if.alu_out, 64'd12);
        step(1'b0, 2'b10, R_SUB, 1'b0, 64'h1234, 64'h1234, 64'd0);
        step(1'b0, 2'b10, R_SUB, 1'b0, 64'd0, 64'd1, 64'd0);
        step(1'b0, 2'b00, 11'b11111000010, 1'b1, 64'h100, 64'hDEAD, 64'hFFFF_FFFF_FFFF_FFF8);
        check("ldst_addr", ex_if.alu_out, 64'hF8);
        step(1'b0, 2'b01, 11'b10110100000, 1'b0, 64'hFFFF_FFFF, 64'd0, 64'd5);
        step(1'b0, 2'b01, 11'b10110100000, 1'b0, 64'h1234_5678, 64'd3, 64'd5);
        check("cbz_passb", ex_if.alu_out, 64'd3);
        step(1'b0, 2'b10, R_ADD, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0);
        step(1'b0, 2'b10, 11'b00000000000, 1'b0, 64'h55, 64'h66, 64'd0);
        step(1'b0, 2'b11, 11'b00000000001, 1'b1, 64'h55, 64'h66, 64'h1);
        step(1'b0, 2'b10, R_SUB, 1'b0, 64'h8000_0000_0000_0000, 64'd1, 64'd0);
        step(1'b0, 2'b11, 11'b11010001001, 1'b1, 64'd10, 64'd0, 64'd3);

        // Reset wins over live inputs, then capture resumes
        step(1'b1, 2'b10, R_ADD, 1'b0, 64'd5, 64'd7, 64'd0);
        step(1'b0, 2'b10, R_ADD, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0);

        for (int i = 0; i < 40; i++) begin
            logic [1:0]  aop;
            logic [10:0] opc;
            aop = 2'($urandom_range(0, 3));
            opc = opcs[$urandom_range(0, 9)];
            if (aop == 2'b11) opc[0] = 1'($urandom_range(0, 1));
            step(1'b0, aop, opc, 1'($urandom_range(0, 1)),
                 {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/legv8_execute_unit.md
Name: legv8_execute_unit

Overview:
- Execute stage of the single-cycle LEGv8 CPU: ALUSrc operand mux, ALU control decode and 64-bit ALU in one block.
- Produces the data-path result (memory address or writeback data) and the Zero flag that qualifies CBZ branching.
- Outputs are registered once so the block presents a clean clock/reset boundary.
- The branch-target adder stays outside this block.

Parameters:
- WIDTH, 64, datapath width in bits (all arithmetic rules below assume 64).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- alu_op  input  2  from control unit: 00 load/store, 01 CBZ, 10 R-type, 11 I-type.
- opcode  input  11  instruction[31:21].
- alu_src  input  1  0 = operand B from read2, 1 = from sign_ext.
- read1  input  WIDTH  register operand A.
- read2  input  WIDTH  register operand B.
- sign_ext  input  WIDTH  sign-extended immediate/offset.
- alu_ctrl  output  4  decoded ALU function (combinational, for debug).
- alu_out  output  WIDTH  registered ALU result.
- zero  output  1  registered (alu_out == 0).
- negative  output  1  registered result[63].
- carry  output  1  registered carry-out.
- overflow  output  1  registered signed overflow.
- illegal  output  1  registered: opcode not decodable under alu_op 10/11.

Behaviour:
- Operand B mux: B = alu_src ? sign_ext : read2. Combinational, no latency.
- ALU control decode (combinational), by alu_op:
  - 00 -> 0010 ADD.
  - 01 -> 0111 PASS-B.
  - 10, by opcode:
    - 10001011000 ADD -> 0010
    - 11001011000 SUB -> 0110
    - 10001010000 AND -> 0000
    - 10101010000 ORR -> 0001
    - 11001010000 EOR -> 0011
    - other -> 1111, illegal.
  - 11, by opcode[10:1]:
    - 1001000100 ADDI -> 0010
    - 1101000100 SUBI -> 0110
    - 1001001000 ANDI -> 0000
    - 1011001000 ORRI -> 0001
    - other -> 1111, illegal.
- ALU functions (A = read1, B = mux output):
  - 0000: A & B.
  - 0001: A | B.
  - 0010: A + B.
  - 0011: A ^ B.
  - 0110: A - B, computed as A + ~B + 1.
  - 0111: B.
  - 1100: ~(A | B).
  - Any other code: result 0.
- Flags:
  - ADD: carry = bit-64 carry out. SUB: carry = carry out of A + ~B + 1 (1 means no borrow).
  - overflow (ADD/SUB only): A and B' share a sign and the result sign differs, where B' is B for ADD and ~B for SUB.
  - Logic, pass and undefined codes: carry = overflow = 0.
  - zero = (result == 0); negative = result[63].
- Timing:
  - Latency of exactly 1 cycle: inputs present before rising edge N appear on alu_out/flags after edge N.
  - Every edge updates the registers; there is no enable or stall.
- Reset:
  - On a rising edge with reset = 1: alu_out = 0, zero = 1, negative = carry = overflow = illegal = 0.
  - Reset has priority over new inputs. Deasserting reset resumes normal capture on the next edge.
  - alu_ctrl is combinational and unaffected by reset.
- Arithmetic is modulo 2^64 with wrap-around; no saturation.

Decomposition:
- Shared package legv8_pkg holds:
  - ALU function codes: ALU_AND=0000, ALU_ORR=0001, ALU_ADD=0010, ALU_EOR=0011, ALU_SUB=0110, ALU_PASSB=0111, ALU_NOR=1100, ALU_BAD=1111.
  - ALUOp encodings.
  - The 11-bit R-type opcodes and 10-bit I-type opcodes.
- One natural sub-module: legv8_alu_decode (alu_op, opcode -> alu_ctrl, illegal).
- The operand mux and ALU core stay inline in the top level.

Test Plan:
- Reset: hold reset 2 cycles with arbitrary inputs -> alu_out=0, zero=1, all other flags 0.
- R-type ADD: alu_op=10, opcode=10001011000, alu_src=0, read1=5, read2=7 -> next cycle alu_out=12, zero=0, alu_ctrl=0010.
- SUB to zero and borrow:
  - opcode=11001011000, read1=read2=0x1234 -> alu_out=0, zero=1, carry=1.
  - read1=0, read2=1 -> alu_out=0xFFFF_FFFF_FFFF_FFFF, negative=1, carry=0.
- Load/store address via immediate: alu_op=00, alu_src=1, read1=0x100, sign_ext=0xFFFF_FFFF_FFFF_FFF8 (-8), read2=0xDEAD -> alu_out=0xF8, carry=1.
- CBZ pass-B: alu_op=01, alu_src=0, read2=0 -> zero=1. read2=3 -> zero=0, alu_out=3. read1 must not affect the result.
- Overflow and illegal:
  - ADD with read1=0x7FFF_FFFF_FFFF_FFFF, read2=1 -> alu_out=0x8000_0000_0000_0000, overflow=1, negative=1.
  - alu_op=10, opcode=00000000000 -> alu_ctrl=1111, illegal=1, alu_out=0, zero=1.
